// File: rtl/chess_input_ctrl.sv
// Chess-clock input front end: button conditioning (sync, debounce, press pulse) and turn FSM.
// Optional macro MOVE_COUNTER_EN enables the saturating full-move counter on MOVES.
module chess_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       BTN_P1,
  input  logic       BTN_P2,
  input  logic       BTN_PAUSE,
  input  logic       BTN_NEW,
  input  logic       OVERFLOW1,
  input  logic       OVERFLOW2,
  output logic       CE,
  output logic       SELECT,
  output logic       STOP,
  output logic       GAME_CLR,
  output logic       GAME_OVER,
  output logic       LOSER,
  output logic [9:0] MOVES
);

  localparam int              NB      = 4;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RUN_P1, RUN_P2, PAUSED, FLAG} state_t;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]   level_q, level_d, pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q [NB];
  logic [DB_W-1:0] cnt_d [NB];

  assign btn_raw = {BTN_NEW, BTN_PAUSE, BTN_P2, BTN_P1};

  // Debounce: a level is accepted only after it differs from the accepted one for DEBOUNCE_CYCLES samples.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic new_p, pause_p, p2_p, p1_p;
  assign {new_p, pause_p, p2_p, p1_p} = pulse_q;

  state_t state_q, state_d;
  logic   ce_q, ce_d, select_q, select_d, stop_q, stop_d;
  logic   game_clr_q, game_clr_d, clr_hold_q, clr_hold_d;
  logic   game_over_q, game_over_d, loser_q, loser_d;

  // Priority: NEW, then the running player's overflow, then PAUSE, then player presses.
  always_comb begin
    state_d    = state_q;
    loser_d    = loser_q;
    clr_hold_d = 1'b0;
    game_clr_d = clr_hold_q;
    if (new_p) begin
      state_d    = IDLE;
      loser_d    = 1'b0;
      game_clr_d = 1'b1;
      clr_hold_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (p1_p)      state_d = RUN_P2;
          else if (p2_p) state_d = RUN_P1;
        end
        RUN_P1: begin
          if (OVERFLOW1) begin
            state_d = FLAG;
            loser_d = 1'b0;
          end else if (pause_p) state_d = PAUSED;
          else if (p1_p)        state_d = RUN_P2;
        end
        RUN_P2: begin
          if (OVERFLOW2) begin
            state_d = FLAG;
            loser_d = 1'b1;
          end else if (pause_p) state_d = PAUSED;
          else if (p2_p)        state_d = RUN_P1;
        end
        PAUSED: begin
          if (pause_p) state_d = select_q ? RUN_P2 : RUN_P1;
        end
        FLAG:    state_d = FLAG;
        default: state_d = IDLE;
      endcase
    end

    ce_d        = (state_d != IDLE);
    stop_d      = !((state_d == RUN_P1) || (state_d == RUN_P2));
    game_over_d = (state_d == FLAG);
    select_d    = select_q;
    if ((state_d == IDLE) || (state_d == RUN_P1)) select_d = 1'b0;
    else if (state_d == RUN_P2)                   select_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= IDLE;
      ce_q        <= 1'b0;
      select_q    <= 1'b0;
      stop_q      <= 1'b1;
      game_clr_q  <= 1'b1;
      clr_hold_q  <= 1'b1;
      game_over_q <= 1'b0;
      loser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      select_q    <= select_d;
      stop_q      <= stop_d;
      game_clr_q  <= game_clr_d;
      clr_hold_q  <= clr_hold_d;
      game_over_q <= game_over_d;
      loser_q     <= loser_d;
    end
  end

  assign CE        = ce_q;
  assign SELECT    = select_q;
  assign STOP      = stop_q;
  assign GAME_CLR  = game_clr_q;
  assign GAME_OVER = game_over_q;
  assign LOSER     = loser_q;

`ifdef MOVE_COUNTER_EN
  logic [9:0] moves_q, moves_d;

  // A full move completes when player 2 hands the turn back to player 1.
  always_comb begin
    moves_d = moves_q;
    if (new_p) begin
      moves_d = '0;
    end else if ((state_q == RUN_P2) && !OVERFLOW2 && !pause_p && p2_p &&
                 (moves_q != 10'd999)) begin
      moves_d = moves_q + 10'd1;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) moves_q <= '0;
    else        moves_q <= moves_d;
  end

  assign MOVES = moves_q;
`else
  assign MOVES = 10'd0;
`endif

endmodule

// File: doc/chess_input_ctrl.md
Name: chess_input_ctrl

Overview:
- Front end that produces the control inputs consumed by the chess-clock top level: CE, SELECT, STOP and the game clear.
- Conditions three raw player push-buttons and one new-game push-button: 2-FF synchroniser, counter debounce, rising-edge press pulse.
- A turn FSM sequences the game and freezes it when either clock reports flag fall (OVERFLOW1/OVERFLOW2).

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised level must stay stable before it is accepted (min 2).
- DB_W, 20, width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- CLR_N  in  1  asynchronous active-low reset
- BTN_P1  in  1  raw, active-high: player 1 ends move
- BTN_P2  in  1  raw, active-high: player 2 ends move
- BTN_PAUSE  in  1  raw, active-high: pause/resume toggle
- BTN_NEW  in  1  raw, active-high: new game
- OVERFLOW1  in  1  player 1 time expired (synchronous to CLK, level)
- OVERFLOW2  in  1  player 2 time expired
- CE  out  1  clock enable to timers
- SELECT  out  1  0 = player 1 timer runs, 1 = player 2 timer runs
- STOP  out  1  1 = both timers halted
- GAME_CLR  out  1  active-high clear to timers
- GAME_OVER  out  1  flag has fallen
- LOSER  out  1  0 = player 1 flagged, 1 = player 2; valid while GAME_OVER
- MOVES  out  10  completed full-move count (see optional feature)

Behaviour:
- Reset (CLR_N low, async): state IDLE, CE=0, SELECT=0, STOP=1, GAME_CLR=1, GAME_OVER=0, LOSER=0, MOVES=0, all sync/debounce regs 0.
- GAME_CLR stays 1 for exactly 2 cycles after CLR_N deasserts, then 0.
- Debounce, per button:
  - sync2 differs from the accepted level: counter increments; otherwise counter clears.
  - Counter reaching DEBOUNCE_CYCLES-1: accepted level updates, counter clears.
  - Press pulse is 1 cycle, on accepted 0->1 only.
  - Latency: pulse is high in the cycle following the (DEBOUNCE_CYCLES+2)-th rising edge that samples the raw input high. Fixed, no jitter.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse. Release generates nothing.
- FSM states: IDLE, RUN_P1, RUN_P2, PAUSED, FLAG. Registered outputs, updated on the edge that consumes the pulse.
  - IDLE: CE=0, STOP=1. P1 press -> RUN_P2. P2 press -> RUN_P1. PAUSE ignored.
  - RUN_P1: CE=1, SELECT=0, STOP=0. P1 press -> RUN_P2. P2 press ignored. PAUSE -> PAUSED. OVERFLOW1 -> FLAG, LOSER=0.
  - RUN_P2: symmetric. P2 press -> RUN_P1. OVERFLOW2 -> FLAG, LOSER=1.
  - PAUSED: CE=1, STOP=1, SELECT held. PAUSE -> resume the saved RUN state. Player presses and overflows ignored.
  - FLAG: CE=1, STOP=1, GAME_OVER=1, SELECT held. Only NEW has effect.
- NEW press from any state: -> IDLE, SELECT=0, GAME_OVER=0, MOVES=0, GAME_CLR=1 for exactly 2 cycles.
- Same-cycle priority: NEW > OVERFLOW of the running player > PAUSE > player press.
  - Overflow of the non-running player is ignored.
  - P1 and P2 pressed in the same cycle: only the running player's press counts; in IDLE, P1 wins.
- Reset mid-operation: immediate return to reset values, including debounce counters; any press in progress is lost.

Optional Feature:
- Macro MOVE_COUNTER_EN.
- Defined:
  - MOVES increments by 1 on every RUN_P2 -> RUN_P1 transition caused by a P2 press.
  - Saturates at 999; cleared by reset and by NEW.
  - Not incremented by pause/resume or by the start from IDLE.
- Undefined: MOVES is constant 0 and no counter logic is instantiated. Port list is identical either way.

Test Plan:
- Reset/clear: DEBOUNCE_CYCLES=4, CLR_N low 3 cycles then high -> CE=0, STOP=1, SELECT=0; GAME_CLR=1 during reset plus exactly 2 cycles after release.
- Debounce: BTN_P1 high 3 cycles then low -> no state change. BTN_P1 held high -> press pulse in the cycle after edge 6; state RUN_P2 (SELECT=1, STOP=0, CE=1) one edge later.
- Turn alternation: start via P2 press -> RUN_P1. Then P2 press ignored (SELECT stays 0); P1 press -> SELECT=1; P2 press -> SELECT=0. With MOVE_COUNTER_EN, MOVES=1; without it, MOVES=0.
- Pause: in RUN_P2 press PAUSE -> STOP=1, SELECT=1; P1 press ignored. PAUSE again -> STOP=0, SELECT=1.
- Flag fall: in RUN_P1 assert OVERFLOW2 -> no change. Assert OVERFLOW1 -> GAME_OVER=1, LOSER=0, STOP=1. PAUSE/P1/P2 presses ignored. NEW -> IDLE, GAME_CLR high 2 cycles, GAME_OVER=0.
- Priority/saturation: NEW and PAUSE pulses in the same cycle during RUN_P1 -> IDLE. With MOVE_COUNTER_EN, 1001 full moves -> MOVES=999.
